// File: rtl/seq_detect_sched.sv
// seq_detect_sched: word scheduler around a serial, overlapping, programmable pattern matcher.
// Each accepted word is shifted MSB-first; the per-word match count is returned by handshake.
module seq_detect_sched #(
  parameter int WIDTH    = 8,
  parameter int PLEN_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_load,
  input  logic [PLEN_MAX-1:0]             cfg_pattern,
  input  logic [$clog2(PLEN_MAX+1)-1:0]   cfg_len,
  input  logic                            in_valid,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [CNT_W-1:0]                out_count,
  input  logic                            out_ready,
  output logic                            match_pulse,
  output logic                            busy
);
  // state  | meaning
  // IDLE   | waiting for a word; config loads accepted
  // SHIFT  | serializing the captured word, one bit per clock
  // REPORT | holding out_count until the consumer takes it
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam int LW = $clog2(PLEN_MAX + 1);
  localparam int BW = $clog2(WIDTH + 1);

  logic [1:0]          state;
  logic [WIDTH-1:0]    word;
  logic [PLEN_MAX-1:0] hist;
  logic [PLEN_MAX-1:0] hist_n;
  logic [PLEN_MAX-1:0] pattern;
  logic [PLEN_MAX-1:0] mask;
  logic [LW-1:0]       len;
  logic [LW-1:0]       len_n;
  logic [BW-1:0]       bits_seen;
  logic [BW-1:0]       bits_n;
  logic [CNT_W-1:0]    count;
  logic                pulse;
  logic                hit;

  // Match is judged on the history as it will look after this cycle's shift.
  always_comb begin
    len_n  = (cfg_len > LW'(PLEN_MAX)) ? LW'(PLEN_MAX) : cfg_len;
    hist_n = {hist[PLEN_MAX-2:0], word[WIDTH-1]};
    bits_n = bits_seen + BW'(1);
    for (int i = 0; i < PLEN_MAX; i++) begin
      mask[i] = (LW'(i) < len);
    end
    hit = (len >= LW'(2)) && (int'(bits_n) >= int'(len)) &&
          (((hist_n ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      word      <= '0;
      hist      <= '0;
      bits_seen <= '0;
      count     <= '0;
      pulse     <= 1'b0;
      pattern   <= PLEN_MAX'(4'b1010);
      len       <= LW'(4);
    end else begin
      pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_n;
          end
          if (in_valid) begin
            word      <= in_data;
            hist      <= '0;
            bits_seen <= '0;
            count     <= '0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          word      <= {word[WIDTH-2:0], 1'b0};
          hist      <= hist_n;
          bits_seen <= bits_n;
          if (hit) begin
            pulse <= 1'b1;
            if (count != '1) count <= count + CNT_W'(1);
          end
          if (bits_n == BW'(WIDTH)) state <= S_REPORT;
        end
        S_REPORT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign out_valid   = (state == S_REPORT);
  assign out_count   = count;
  assign match_pulse = pulse;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench for seq_detect_sched: two instances (CNT_W=4 and CNT_W=2) share stimulus,
// checked against a window-based reference model of the matching rules.
`timescale 1ns/1ps
module tb_seq_detect_sched;
  localparam int WIDTH = 8;
  localparam int PLEN_MAX = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, match_pulse, busy;
  logic [3:0] out_count;
  logic       in_ready2, out_valid2, match_pulse2, busy2;
  logic [1:0] out_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] m_pat;
  int         m_len;

  seq_detect_sched #(.WIDTH(8), .PLEN_MAX(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_count(out_count), .out_ready(out_ready), .match_pulse(match_pulse), .busy(busy));

  seq_detect_sched #(.WIDTH(8), .PLEN_MAX(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_count(out_count2), .out_ready(out_ready), .match_pulse(match_pulse2), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit i (0 = MSB, first received) ends a match when the last len received bits equal the pattern.
  function automatic logic [7:0] model_pulses(input logic [7:0] w, input logic [7:0] p, input int l);
    logic [7:0] r;
    int msk, prefix;
    r = '0;
    if (l < 2) return r;
    msk = (1 << l) - 1;
    for (int i = 0; i < WIDTH; i++) begin
      prefix = int'(w) >> (WIDTH - 1 - i);
      if ((i + 1 >= l) && ((prefix & msk) == (int'(p) & msk))) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model(input logic [7:0] p, input logic [3:0] l);
    m_pat = p;
    m_len = (int'(l) > PLEN_MAX) ? PLEN_MAX : int'(l);
  endtask

  task automatic do_reset();
    reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    m_pat = 8'b1010; m_len = 4;
  endtask

  task automatic cfg_idle(input logic [7:0] p, input logic [3:0] l);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l;
    step();
    cfg_load = 1'b0;
    set_model(p, l);
  endtask

  // cfg_mode: 0 none, 1 load together with the word accept, 2 load during SHIFT
  task automatic send_word(input logic [7:0] w, input int hold, input int cfg_mode,
                           input logic [7:0] cp, input logic [3:0] cl,
                           output logic [7:0] pv4, output logic [7:0] pv2, output int lat,
                           output logic [3:0] c4, output logic [1:0] c2,
                           output logic stable, output logic released, output int t_acc);
    int n;
    pv4 = '0; pv2 = '0; lat = -1; c4 = '0; c2 = '0; stable = 1'b1; released = 1'b0; t_acc = -1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) return;
    in_valid = 1'b1; in_data = w;
    if (cfg_mode == 1) begin
      cfg_load = 1'b1; cfg_pattern = cp; cfg_len = cl; set_model(cp, cl);
    end
    step();
    t_acc = cyc;
    in_valid = 1'b0; cfg_load = 1'b0;
    for (int k = 1; k <= WIDTH + 20; k++) begin
      if (cfg_mode == 2 && k == 2) begin
        cfg_load = 1'b1; cfg_pattern = cp; cfg_len = cl;
      end
      step();
      cfg_load = 1'b0;
      if (k <= WIDTH) begin pv4[k-1] = match_pulse; pv2[k-1] = match_pulse2; end
      if (out_valid && lat < 0) lat = k;
      if (k >= WIDTH && lat >= 0) break;
    end
    if (lat < 0) return;
    c4 = out_count; c2 = out_count2;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b0;
      step();
      if (!(out_valid && out_valid2 && !in_ready && !in_ready2 && busy && !match_pulse &&
            out_count == c4 && out_count2 == c2)) stable = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    released = !out_valid && !out_valid2 && in_ready && in_ready2 && !busy;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    checks++; if (match_pulse !== 1'b0) begin errors++; $display("FAIL reset_match_pulse got %b want 0", match_pulse); end
    checks++; if (busy !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0/0", busy, busy2); end
    checks++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_dut2 got rdy=%b vld=%b want 1/0", in_ready2, out_valid2); end
  endtask

  task automatic test_default();
    logic [7:0] words [4] = '{8'hAA, 8'h0A, 8'h01, 8'h40};
    int want [4] = '{3, 1, 0, 0};
    logic [7:0] pv4, pv2, exp;
    logic [3:0] c4; logic [1:0] c2; logic st, rel; int lat, ta;
    for (int j = 0; j < 4; j++) begin
      send_word(words[j], j % 2, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
      exp = model_pulses(words[j], m_pat, m_len);
      checks++; if (lat !== WIDTH) begin errors++; $display("FAIL default_latency w=%h got %0d want %0d", words[j], lat, WIDTH); end
      checks++; if (pv4 !== exp || pv2 !== exp) begin errors++; $display("FAIL default_pulses w=%h got %b/%b want %b", words[j], pv4, pv2, exp); end
      checks++; if (int'(c4) !== want[j]) begin errors++; $display("FAIL default_count w=%h got %0d want %0d", words[j], c4, want[j]); end
      checks++; if (int'(c2) !== sat(want[j], 3)) begin errors++; $display("FAIL default_count2 w=%h got %0d want %0d", words[j], c2, sat(want[j], 3)); end
      checks++; if (!(st && rel)) begin errors++; $display("FAIL default_handshake w=%h got stable=%b released=%b want 1/1", words[j], st, rel); end
    end
  endtask

  task automatic test_cfg();
    logic [7:0] pv4, pv2;
    logic [3:0] c4; logic [1:0] c2; logic st, rel; int lat, ta;
    cfg_idle(8'b111, 4'd3);
    send_word(8'hFF, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd6 || c2 !== 2'd3) begin errors++; $display("FAIL cfg_111_ff got %0d/%0d want 6/3", c4, c2); end
    send_word(8'hFF, 0, 2, 8'b1010, 4'd4, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd6) begin errors++; $display("FAIL cfg_mid_shift_word got %0d want 6", c4); end
    send_word(8'hAA, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd0) begin errors++; $display("FAIL cfg_mid_shift_ignored got %0d want 0", c4); end
    send_word(8'hAA, 0, 1, 8'b1010, 4'd4, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd3) begin errors++; $display("FAIL cfg_with_accept got %0d want 3", c4); end
    cfg_idle(8'hA5, 4'd12);
    send_word(8'hA5, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd1 || pv4 !== 8'h80) begin errors++; $display("FAIL cfg_clamp_hit got %0d pulses %b want 1 10000000", c4, pv4); end
    send_word(8'hA4, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd0) begin errors++; $display("FAIL cfg_clamp_miss got %0d want 0", c4); end
    cfg_idle(8'h01, 4'd1);
    send_word(8'hFF, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd0 || pv4 !== 8'h00) begin errors++; $display("FAIL cfg_len1 got %0d pulses %b want 0", c4, pv4); end
    cfg_idle(8'h00, 4'd0);
    send_word(8'h00, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd0 || pv4 !== 8'h00) begin errors++; $display("FAIL cfg_len0 got %0d pulses %b want 0", c4, pv4); end
  endtask

  task automatic test_backpressure();
    logic [7:0] pv4, pv2;
    logic [3:0] c4; logic [1:0] c2; logic st, rel; int lat, ta;
    cfg_idle(8'b1010, 4'd4);
    send_word(8'hAA, 5, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", st); end
    checks++; if (rel !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", rel); end
    checks++; if (c4 !== 4'd3) begin errors++; $display("FAIL bp_count got %0d want 3", c4); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pv4, pv2;
    logic [3:0] c4; logic [1:0] c2; logic st, rel; int lat, ta;
    cfg_idle(8'b111, 4'd3);
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_pat = 8'b1010; m_len = 4;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got rdy=%b busy=%b want 1/0", in_ready, busy); end
    checks++; if (out_valid !== 1'b0 || out_count !== 4'd0 || match_pulse !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got vld=%b cnt=%0d pulse=%b want 0/0/0", out_valid, out_count, match_pulse); end
    send_word(8'hAA, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c4 !== 4'd3 || lat !== WIDTH) begin errors++; $display("FAIL midreset_next_word got cnt=%0d lat=%0d want 3/%0d", c4, lat, WIDTH); end
  endtask

  task automatic test_saturation();
    logic [7:0] pv4, pv2;
    logic [3:0] c4; logic [1:0] c2; logic st, rel; int lat, ta;
    cfg_idle(8'b11, 4'd2);
    send_word(8'hFF, 2, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta);
    checks++; if (c2 !== 2'd3) begin errors++; $display("FAIL sat_count2 got %0d want 3", c2); end
    checks++; if (c4 !== 4'd7) begin errors++; $display("FAIL sat_count4 got %0d want 7", c4); end
    checks++; if ($countones(pv2) !== 7) begin errors++; $display("FAIL sat_pulses2 got %0d want 7", $countones(pv2)); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL sat_hold got %b want 1", st); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pv4, pv2;
    logic [3:0] c4; logic [1:0] c2; logic st, rel; int lat, ta1, ta2;
    cfg_idle(8'b1010, 4'd4);
    send_word(8'hAA, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta1);
    send_word(8'h0A, 0, 0, 8'h00, 4'd0, pv4, pv2, lat, c4, c2, st, rel, ta2);
    checks++; if (ta2 - ta1 !== WIDTH + 2) begin errors++; $display("FAIL b2b_period got %0d want %0d", ta2 - ta1, WIDTH + 2); end
    checks++; if (c4 !== 4'd1) begin errors++; $display("FAIL b2b_second_count got %0d want 1", c4); end
  endtask

  task automatic test_random();
    logic [7:0] pv4, pv2, exp, w, cp;
    logic [3:0] c4, cl; logic [1:0] c2; logic st, rel; int lat, ta, raw, mode;
    for (int j = 0; j < 40; j++) begin
      cp = 8'($urandom);
      cl = 4'($urandom_range(0, 15));
      mode = 0;
      if (j % 4 == 0) cfg_idle(cp, cl);
      else if (j % 4 == 1) mode = 1;
      else if (j % 4 == 2) mode = 2;
      w = ($urandom_range(0, 1) == 1) ? 8'($urandom) : cp;
      send_word(w, int'($urandom_range(0, 3)), mode, cp, cl, pv4, pv2, lat, c4, c2, st, rel, ta);
      exp = model_pulses(w, m_pat, m_len);
      raw = $countones(exp);
      checks++; if (pv4 !== exp || lat !== WIDTH) begin
        errors++; $display("FAIL rand_pulses w=%h p=%h l=%0d got %b lat=%0d want %b lat=%0d", w, m_pat, m_len, pv4, lat, exp, WIDTH); end
      checks++; if (int'(c4) !== sat(raw, 15) || int'(c2) !== sat(raw, 3)) begin
        errors++; $display("FAIL rand_count w=%h p=%h l=%0d got %0d/%0d want %0d/%0d", w, m_pat, m_len, c4, c2, sat(raw, 15), sat(raw, 3)); end
      checks++; if (!(st && rel)) begin errors++; $display("FAIL rand_handshake w=%h got %b/%b want 1/1", w, st, rel); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_cfg();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
Word-level scheduler and controller for the serial overlapping pattern detector.
- Accepts parallel words over a valid/ready handshake.
- Serializes each word MSB-first, one bit per clock, into an internal programmable shift-register matcher (overlap allowed).
- Counts matches per word and returns the count over a valid/ready result channel.
- Sits between a word-oriented producer and consumer, and owns the detector's pattern and length configuration.

Parameters:
WIDTH, 8, input word width in bits (>=2)
PLEN_MAX, 8, maximum pattern length in bits (2..WIDTH)
CNT_W, 4, width of per-word match count

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cfg_load  input  1  load cfg_pattern/cfg_len; honoured only in IDLE
cfg_pattern  input  PLEN_MAX  pattern; bit cfg_len-1 is the first bit received, bit 0 the last
cfg_len  input  $clog2(PLEN_MAX+1)  active pattern length
in_valid  input  1  word offered
in_data  input  WIDTH  word to scan, MSB shifted first
in_ready  output  1  scheduler can accept a word
out_valid  output  1  per-word result available
out_count  output  CNT_W  matches found in the word
out_ready  input  1  consumer accepts result
match_pulse  output  1  one-cycle strobe per detected match
busy  output  1  high in SHIFT or REPORT

Behaviour:
- Reset values (sync, active-high, overrides all other inputs):
  - state=IDLE; in_ready=1; out_valid=0; out_count=0; match_pulse=0; busy=0.
  - History cleared; bit index=0.
  - Config = pattern 'b1010 (zero-extended), len=4.
  - Any in-flight word or pending result is dropped.
- States: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data, clear history, bit-seen count and match count; go to SHIFT.
  - cfg_load in the same cycle as a word accept is applied first; the captured word uses the new config.
- SHIFT:
  - in_ready=0; lasts exactly WIDTH cycles.
  - Each cycle shifts the next bit (MSB first) into history: hist <= {hist[PLEN_MAX-2:0], bit}; increments bits_seen.
  - Match condition on the updated history: bits_seen>=len && hist[len-1:0]==pattern[len-1:0].
  - On a match: match_pulse=1 in the following cycle and count increments.
  - After bit 0 is shifted, go to REPORT.
  - cfg_load is ignored.
- REPORT:
  - out_valid=1; out_count holds the final count (including the last bit's match); both stay stable until out_ready.
  - On out_valid&&out_ready: go to IDLE and drop out_valid the next cycle.
  - in_ready=0; cfg_load is ignored.
- Latency:
  - Word accepted at edge t0 → out_valid high from cycle t0+WIDTH.
  - Minimum word-to-word period is WIDTH+2 cycles.
- Overlap and word boundaries:
  - Overlapping matches within a word are counted; e.g. 1010 in 1010101 gives 2.
  - No match spans a word boundary (history is cleared per word).
- Arithmetic: count saturates at 2^CNT_W-1 and never wraps.
- Config edge cases:
  - cfg_len=0 or 1: never matches (count=0).
  - cfg_len>PLEN_MAX: clamped to PLEN_MAX at load.
  - cfg_len>WIDTH cannot match.
- match_pulse for the final bit coincides with the first REPORT cycle.
- busy = (state!=IDLE).
- Illegal state encodings recover to IDLE on the next clock.

Test Plan:
- Default config after reset; word 0xAA (10101010) → match_pulse 3 times; out_valid at t0+8; out_count=3.
- Word 0x0A → out_count=1. Word 0x01 then word 0x40 → counts 0 and 0, showing no cross-word match.
- cfg_load pattern 'b111, len=3 in IDLE; word 0xFF → out_count=6. cfg_load during SHIFT → ignored; the next word still uses the old config.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT → out_valid=1 and out_count stable; in_ready=0 and in_valid is ignored throughout. out_ready=1 → IDLE the next cycle, in_ready=1.
- Assert reset at the 4th SHIFT cycle of 0xAA → next cycle state IDLE, in_ready=1, out_valid=0, config=1010/len4. The following word 0xAA → count=3.
- Saturation: CNT_W=2, pattern 'b11, len=2, word 0xFF → out_count=3 (not 7 mod 4); match_pulse still fires 7 times.
